// File: rtl/arb_muxn_if.sv
// arb_muxn_if: N-channel input bundle plus single output
// handshake, with the mux on the slave side.
interface arb_muxn_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               rr_en;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, sel, rr_en, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, sel, rr_en, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/arb_muxn.sv
// arb_muxn: N-input mux with explicit or round-robin select
// and a one-entry registered output stage.
module arb_muxn #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic      clk,
    input  logic      reset_n,
    arb_muxn_if.slave bus
);
    logic [SELW-1:0]  rr_ptr;
    logic             load_en;
    logic             sel_ok;
    logic             ex_gnt_v;
    logic             rr_gnt_v;
    logic [SELW-1:0]  rr_gnt;
    logic [SELW-1:0]  cand;
    logic             gnt_v;
    logic [SELW-1:0]  gnt;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    assign load_en = !bus.out_valid || bus.out_ready;

    // explicit select: out-of-range index never grants
    always_comb begin
        sel_ok   = int'(bus.sel) < N;
        ex_gnt_v = sel_ok ? bus.in_valid[bus.sel] : 1'b0;
    end

    // round-robin: first valid channel after rr_ptr, wrapping
    always_comb begin
        rr_gnt_v = 1'b0;
        rr_gnt   = '0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SELW'((int'(rr_ptr) + k) % N);
            if (!rr_gnt_v && bus.in_valid[cand]) begin
                rr_gnt_v = 1'b1;
                rr_gnt   = cand;
            end
        end
    end

    // pick the active grant source, form one-hot ready and data
    always_comb begin
        gnt_v    = bus.rr_en ? rr_gnt_v : ex_gnt_v;
        gnt      = bus.rr_en ? rr_gnt : bus.sel;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = reset_n && load_en && gnt_v
                              && (gnt == SELW'(i));
            if (gnt == SELW'(i))
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign xfer = |(bus.in_ready & bus.in_valid);

    // output register and round-robin pointer update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            rr_ptr        <= SELW'(N - 1);
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= gnt_data;
            bus.out_sel   <= gnt;
            if (bus.rr_en)
                rr_ptr <= gnt;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.in_ready));

    a_stall: assert property (@(posedge clk) disable iff (!reset_n)
        !$past(bus.out_valid && !bus.out_ready)
        || ($stable(bus.out_data) && $stable(bus.out_sel)));

    a_sel: assert property (@(posedge clk) disable iff (!reset_n)
        !bus.out_valid || (int'(bus.out_sel) < N));
endmodule

// File: tb/tb_arb_muxn.sv
// tb_arb_muxn: directed checks of arb_muxn at N=4 and N=3.
module tb_arb_muxn;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arb_muxn_if #(.WIDTH(32), .N(4)) b4 ();
    arb_muxn_if #(.WIDTH(32), .N(3)) b3 ();

    arb_muxn #(.WIDTH(32), .N(4)) u4 (
        .clk(clk), .reset_n(reset_n), .bus(b4)
    );
    arb_muxn #(.WIDTH(32), .N(3)) u3 (
        .clk(clk), .reset_n(reset_n), .bus(b3)
    );

    function automatic logic [31:0] w4(int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] w3(int i);
        return 32'hB000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b4.in_valid  = '0;
        b4.in_data   = {w4(3), w4(2), w4(1), w4(0)};
        b4.sel       = '0;
        b4.rr_en     = 1'b0;
        b4.out_ready = 1'b0;
        b3.in_valid  = '0;
        b3.in_data   = {w3(2), w3(1), w3(0)};
        b3.sel       = '0;
        b3.rr_en     = 1'b0;
        b3.out_ready = 1'b1;

        // reset held 3 cycles with all channels requesting
        b4.in_valid = 4'b1111;
        b4.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            edge1();
            chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
            chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
        end
        chk("rst_out_data", b4.out_data, 32'd0);

        // explicit select of channel 2
        reset_n  = 1'b1;
        b4.rr_en = 1'b0;
        b4.sel   = 2'd2;
        #1;
        chk("ex_in_ready", 32'(b4.in_ready), 32'b0100);
        edge1();
        chk("ex_out_valid", 32'(b4.out_valid), 32'd1);
        chk("ex_out_data", b4.out_data, w4(2));
        chk("ex_out_sel", 32'(b4.out_sel), 32'd2);

        // round-robin, all valid; pointer still at 3
        b4.rr_en = 1'b1;
        #1;
        chk("rr_first_ready", 32'(b4.in_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            edge1();
            chk("rr_all_sel", 32'(b4.out_sel), 32'(k % 4));
            chk("rr_all_data", b4.out_data, w4(k % 4));
        end

        // only channels 1 and 3 valid, pointer at 1
        b4.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            edge1();
            chk("rr_alt_sel", 32'(b4.out_sel),
                (k % 2 == 0) ? 32'd3 : 32'd1);
        end

        // backpressure with channel 1 word held
        b4.out_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(b4.in_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            edge1();
            chk("bp_valid", 32'(b4.out_valid), 32'd1);
            chk("bp_sel", 32'(b4.out_sel), 32'd1);
            chk("bp_data", b4.out_data, w4(1));
            chk("bp_ready", 32'(b4.in_ready), 32'd0);
        end
        b4.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(b4.in_ready), 32'b1000);
        edge1();
        chk("bp_b2b_valid", 32'(b4.out_valid), 32'd1);
        chk("bp_b2b_sel", 32'(b4.out_sel), 32'd3);
        chk("bp_b2b_data", b4.out_data, w4(3));
        b4.in_valid = 4'b0000;
        edge1();
        chk("drain_valid", 32'(b4.out_valid), 32'd0);
        chk("drain_hold_sel", 32'(b4.out_sel), 32'd3);

        // mode switch: rr 0,1 then explicit 3,3 then rr -> 2
        b4.in_valid = 4'b1111;
        edge1();
        chk("ms_rr0", 32'(b4.out_sel), 32'd0);
        edge1();
        chk("ms_rr1", 32'(b4.out_sel), 32'd1);
        b4.rr_en = 1'b0;
        b4.sel   = 2'd3;
        edge1();
        chk("ms_ex3a", 32'(b4.out_sel), 32'd3);
        edge1();
        chk("ms_ex3b", 32'(b4.out_sel), 32'd3);
        b4.rr_en = 1'b1;
        edge1();
        chk("ms_rr2", 32'(b4.out_sel), 32'd2);
        chk("ms_rr2_data", b4.out_data, w4(2));

        // async reset between edges while stalled
        b4.out_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(b4.out_valid), 32'd0);
        chk("mid_rst_sel", 32'(b4.out_sel), 32'd0);
        chk("mid_rst_ready", 32'(b4.in_ready), 32'd0);
        edge1();
        reset_n      = 1'b1;
        b4.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(b4.in_ready), 32'b0001);
        edge1();
        chk("post_rst_sel", 32'(b4.out_sel), 32'd0);
        chk("post_rst_valid", 32'(b4.out_valid), 32'd1);

        // N=3: out-of-range explicit select never grants
        b3.in_valid = 3'b111;
        b3.sel      = 2'd1;
        edge1();
        chk("n3_ex1_sel", 32'(b3.out_sel), 32'd1);
        chk("n3_ex1_valid", 32'(b3.out_valid), 32'd1);
        b3.sel = 2'd3;
        #1;
        chk("n3_sel3_ready", 32'(b3.in_ready), 32'd0);
        edge1();
        chk("n3_sel3_valid", 32'(b3.out_valid), 32'd0);

        // N=3: pointer at 2 from reset, only channel 0 -> wrap
        b3.rr_en    = 1'b1;
        b3.in_valid = 3'b001;
        #1;
        chk("n3_wrap_ready", 32'(b3.in_ready), 32'b001);
        edge1();
        chk("n3_wrap_sel", 32'(b3.out_sel), 32'd0);
        chk("n3_wrap_data", b3.out_data, w3(0));
        b3.in_valid = 3'b101;
        edge1();
        chk("n3_rr_sel2", 32'(b3.out_sel), 32'd2);
        edge1();
        chk("n3_rr_sel0", 32'(b3.out_sel), 32'd0);

        b3.in_valid = '0;
        b4.in_valid = '0;
        edge1();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
